// File: rtl/nms_pkg.sv
// Shared definitions for the streaming non-maximum-suppression block:
// gradient direction codes, FSM state type and output width.
package nms_pkg;

  localparam int unsigned DIR_W = 3;
  localparam int unsigned OUT_W = 8;

  // Canonical direction codes; 4..7 alias onto these (4->NS, 5,6->NWSE, 7->EW)
  localparam logic [DIR_W-1:0] DIR_EW   = 3'd0;
  localparam logic [DIR_W-1:0] DIR_NESW = 3'd1;
  localparam logic [DIR_W-1:0] DIR_NS   = 3'd2;
  localparam logic [DIR_W-1:0] DIR_NWSE = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_FLUSH
  } state_t;

endpackage

// File: rtl/nms_line_buf.sv
// One-line delay: every enabled cycle reads the word written DEPTH
// enables ago and overwrites it with din.
// Ports: clk, rst_n (sync, active-low, pointer only), en (advance),
//        din (new word), dout (word from DEPTH advances earlier).
module nms_line_buf #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;

  assign dout = mem[ptr];

  // Circular pointer; contents are never cleared
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/nms_stream.sv
// Streaming 3x3 non-maximum suppression over a raster image.
// Two line delays plus a 3-column shift window give the neighbourhood of
// the pixel one line and one pixel behind the input; flush injects zero
// pixels so the last line drains out.
// Ports: clk, rst_n (sync, active-low); s_valid/s_ready/s_mag/s_dir/s_sof
//        input stream; m_valid/m_ready/m_data/m_sof/m_eol output stream;
//        thr_lo/thr_hi hysteresis thresholds.
// Build option: NMS_HYST_EN replaces saturation with 0/128/255 classing.
module nms_stream
  import nms_pkg::*;
#(
  parameter int unsigned MAG_WIDTH = 12,
  parameter int unsigned IMG_W     = 640,
  parameter int unsigned IMG_H     = 480
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [MAG_WIDTH-1:0] s_mag,
  input  logic [2:0]           s_dir,
  input  logic                 s_sof,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [7:0]           m_data,
  output logic                 m_sof,
  output logic                 m_eol,
  input  logic [MAG_WIDTH-1:0] thr_lo,
  input  logic [MAG_WIDTH-1:0] thr_hi
);

  localparam int unsigned PIX_W = MAG_WIDTH + DIR_W;
  localparam int unsigned TOTAL = IMG_W * IMG_H;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);
  localparam int unsigned FL_W  = $clog2(IMG_W + 2);
  localparam int unsigned X_W   = $clog2(IMG_W);
  localparam int unsigned Y_W   = $clog2(IMG_H);

  state_t               state;
  logic [CNT_W-1:0]     in_cnt;
  logic [FL_W-1:0]      fl_cnt;
  logic [X_W-1:0]       ox;
  logic [Y_W-1:0]       oy;

  logic                 adv, take, start, take_pix, inject, shift, emit;
  logic [PIX_W-1:0]     pix, lb0_q, lb1_q;
  logic [MAG_WIDTH-1:0] top0, top1, top2, mid0, mid1, mid2, bot0, bot1, bot2;
  logic [MAG_WIDTH-1:0] n1, n2;
  logic [DIR_W-1:0]     c_dir;
  logic                 border, keep;
  logic [OUT_W-1:0]     value, pix_out;
  logic                 unused_dir;

  // Handshake and pipeline-advance decode
  always_comb begin
    adv     = !m_valid || m_ready;
    s_ready = 1'b0;
    if (rst_n) begin
      case (state)
        ST_IDLE:        s_ready = 1'b1;
        ST_FILL, ST_RUN: s_ready = adv;
        default:        s_ready = 1'b0;
      endcase
    end
    take     = s_valid && s_ready;
    start    = take && s_sof;
    // IDLE drops everything except a frame start
    take_pix = take && ((state != ST_IDLE) || s_sof);
    inject   = (state == ST_FLUSH) && adv && (fl_cnt != FL_W'(IMG_W + 1));
    shift    = take_pix || inject;
    emit     = inject || ((state == ST_RUN) && take && !s_sof);
    pix      = inject ? '0 : {s_dir, s_mag};
  end

  nms_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (shift),
    .din  (pix),
    .dout (lb0_q)
  );

  nms_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (shift),
    .din  (lb0_q),
    .dout (lb1_q)
  );

  // Newest window column: two lines up, one line up, current pixel
  assign top2       = lb1_q[MAG_WIDTH-1:0];
  assign mid2       = lb0_q[MAG_WIDTH-1:0];
  assign bot2       = pix[MAG_WIDTH-1:0];
  assign unused_dir = ^lb1_q[PIX_W-1:MAG_WIDTH];

  // Window shift; mid1/c_dir is the center once the new column is added
  always_ff @(posedge clk) begin
    if (shift) begin
      top0  <= top1;
      top1  <= top2;
      mid0  <= mid1;
      mid1  <= mid2;
      bot0  <= bot1;
      bot1  <= bot2;
      c_dir <= lb0_q[PIX_W-1:MAG_WIDTH];
    end
  end

  // Neighbour pair, suppression and output value for the center
  always_comb begin
    n1 = top0;
    n2 = bot2;
    case (c_dir)
      DIR_EW, 3'd7: begin n1 = mid0; n2 = mid2; end
      DIR_NESW:     begin n1 = top2; n2 = bot0; end
      DIR_NS, 3'd4: begin n1 = top1; n2 = bot1; end
      default:      begin n1 = top0; n2 = bot2; end  // DIR_NWSE, 5, 6
    endcase
    keep = (mid1 >= n1) && (mid1 >= n2);
`ifdef NMS_HYST_EN
    if (!keep)              value = '0;
    else if (mid1 >= thr_hi) value = 8'd255;
    else if (mid1 >= thr_lo) value = 8'd128;
    else                     value = '0;
`else
    if (!keep)                   value = '0;
    else if (32'(mid1) > 32'd255) value = 8'd255;
    else                          value = 8'(mid1);
`endif
    border  = (ox == '0) || (ox == X_W'(IMG_W - 1)) ||
              (oy == '0) || (oy == Y_W'(IMG_H - 1));
    pix_out = border ? '0 : value;
  end

`ifndef NMS_HYST_EN
  logic unused_thr;
  assign unused_thr = ^{thr_lo, thr_hi};
`endif

  // Frame FSM, counters and registered output stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      in_cnt  <= '0;
      fl_cnt  <= '0;
      ox      <= '0;
      oy      <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
    end else begin
      if (adv) begin
        m_valid <= emit;
        if (emit) begin
          m_data <= pix_out;
          m_sof  <= (ox == '0) && (oy == '0);
          m_eol  <= (ox == X_W'(IMG_W - 1));
        end
      end
      if (emit) begin
        if (ox == X_W'(IMG_W - 1)) begin
          ox <= '0;
          oy <= (oy == Y_W'(IMG_H - 1)) ? '0 : oy + Y_W'(1);
        end else begin
          ox <= ox + X_W'(1);
        end
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_FILL;
            in_cnt <= CNT_W'(1);
            ox     <= '0;
            oy     <= '0;
          end
        end
        ST_FILL, ST_RUN: begin
          // A new start abandons whatever the window still holds
          if (start) begin
            state  <= ST_FILL;
            in_cnt <= CNT_W'(1);
            ox     <= '0;
            oy     <= '0;
          end else if (take) begin
            in_cnt <= in_cnt + CNT_W'(1);
            if ((state == ST_FILL) && (in_cnt == CNT_W'(IMG_W))) begin
              state <= ST_RUN;
            end
            if ((state == ST_RUN) && (in_cnt == CNT_W'(TOTAL - 1))) begin
              state  <= ST_FLUSH;
              fl_cnt <= '0;
            end
          end
        end
        ST_FLUSH: begin
          if (inject) begin
            fl_cnt <= fl_cnt + FL_W'(1);
          end else if (adv) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nms_stream.sv
// Bench for nms_stream on a 5x5 image: directed and random frames are
// compared pixel by pixel with a 2-D reference of the suppression rules.
module tb_nms_stream;

  localparam int W   = 5;
  localparam int H   = 5;
  localparam int N   = W * H;
  localparam int TLO = 20;
  localparam int THI = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, s_sof;
  logic [11:0] s_mag;
  logic [2:0]  s_dir;
  logic        m_valid, m_sof, m_eol;
  logic        m_ready = 1'b1;
  logic [7:0]  m_data;
  logic [11:0] thr_lo, thr_hi;

  int checks = 0;
  int errors = 0;
  int img_mag [N];
  int img_dir [N];
  logic [9:0] cap [$];
  int ready_mode = 0;
  bit gaps = 1'b0;

  always #5 clk = ~clk;

  nms_stream #(.MAG_WIDTH(12), .IMG_W(W), .IMG_H(H)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_mag  (s_mag),
    .s_dir  (s_dir),
    .s_sof  (s_sof),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_sof  (m_sof),
    .m_eol  (m_eol),
    .thr_lo (thr_lo),
    .thr_hi (thr_hi)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Downstream ready: 0 always ready, 1 toggling, 2 random
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output capture at handshakes and hold check while stalled
  logic [9:0] prev_out;
  bit prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) cap.push_back({m_data, m_sof, m_eol});
    if (prev_stall && rst_n)
      chk("stall_hold", int'({m_valid, m_data, m_sof, m_eol}), int'({1'b1, prev_out}));
    prev_stall = rst_n && m_valid && !m_ready;
    prev_out   = {m_data, m_sof, m_eol};
  end

  // Reference: value of a kept center after saturation or classing
  function automatic int classify(int c);
`ifdef NMS_HYST_EN
    if (c >= THI) return 255;
    if (c >= TLO) return 128;
    return 0;
`else
    return (c > 255) ? 255 : c;
`endif
  endfunction

  // Reference: thinned output at (x,y) from the stored image
  function automatic int ref_pix(int x, int y);
    int c, dx, dy, n1, n2;
    if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 0;
    c = img_mag[y * W + x];
    case (img_dir[y * W + x])
      0, 7:    begin dx = 1; dy = 0;  end  // E and W
      1:       begin dx = 1; dy = -1; end  // NE and SW
      2, 4:    begin dx = 0; dy = 1;  end  // S and N
      default: begin dx = 1; dy = 1;  end  // SE and NW
    endcase
    n1 = img_mag[(y + dy) * W + (x + dx)];
    n2 = img_mag[(y - dy) * W + (x - dx)];
    return (c >= n1 && c >= n2) ? classify(c) : 0;
  endfunction

  task automatic set_flat(input int m, input int d);
    for (int i = 0; i < N; i++) begin img_mag[i] = m; img_dir[i] = d; end
  endtask

  task automatic set_px(input int x, input int y, input int m, input int d);
    img_mag[y * W + x] = m;
    img_dir[y * W + x] = d;
  endtask

  // Present one pixel and hold it until accepted (called at posedge+1)
  task automatic send_px(input int m, input int d, input bit sof);
    int guard = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    s_valid = 1'b1; s_mag = 12'(m); s_dir = 3'(d); s_sof = sof;
    @(negedge clk);
    while (!s_ready && guard < 500) begin guard++; @(negedge clk); end
    if (guard >= 500) chk("s_ready_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic send_frame(input int count);
    for (int i = 0; i < count; i++) send_px(img_mag[i], img_dir[i], i == 0);
  endtask

  task automatic check_frame(input string tag);
    int guard = 0;
    int sofs = 0;
    int e;
    while (cap.size() < N && guard < 3000) begin guard++; @(negedge clk); end
    repeat (30) @(negedge clk);
    chk($sformatf("%s_count", tag), cap.size(), N);
    for (int i = 0; i < N && i < cap.size(); i++) begin
      e = (ref_pix(i % W, i / W) << 2) | ((i == 0) ? 2 : 0) | ((i % W == W - 1) ? 1 : 0);
      chk($sformatf("%s_px%0d", tag, i), int'(cap[i]), e);
      sofs += int'(cap[i][1]);
    end
    chk($sformatf("%s_sof_once", tag), sofs, 1);
  endtask

  function automatic int center_out();
    return (cap.size() > 12) ? int'(cap[12][9:2]) : -1;
  endfunction

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_mag = '0; s_dir = '0;
    thr_lo = 12'(TLO); thr_hi = 12'(THI);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data",  int'(m_data), 0);
    chk("rst_m_sof",   int'(m_sof), 0);
    chk("rst_m_eol",   int'(m_eol), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_s_ready", int'(s_ready), 1);
    @(posedge clk); #1;

    // Flat field: interior ties are kept, border forced to 0
    set_flat(10, 0);
    cap.delete(); send_frame(N); check_frame("flat");
    chk("flat_center", center_out(), classify(10));

    // N/S suppression by a larger south neighbour, then kept and saturated
    set_flat(0, 0);
    set_px(2, 2, 300, 2); set_px(2, 1, 200, 0); set_px(2, 3, 310, 0);
    cap.delete(); send_frame(N); check_frame("ns_supp");
    chk("ns_supp_center", center_out(), 0);
    set_px(2, 3, 299, 0);
    cap.delete(); send_frame(N); check_frame("ns_keep");
    chk("ns_keep_center", center_out(), 255);

    // Diagonal tie on NW is kept
    set_flat(0, 0);
    set_px(2, 2, 50, 6); set_px(1, 1, 50, 0); set_px(3, 3, 49, 0);
    cap.delete(); send_frame(N); check_frame("nwse_tie");
    chk("nwse_tie_center", center_out(), classify(50));

    // Toggling downstream ready over a random frame
    for (int i = 0; i < N; i++) begin
      img_mag[i] = $urandom_range(0, 8) * 50; img_dir[i] = $urandom_range(0, 7);
    end
    ready_mode = 1;
    cap.delete(); send_frame(N); check_frame("toggle");
    ready_mode = 0;

    // Restart after 7 pixels; the one output of the abandoned frame is
    // drained before capture so only the restarted frame is counted
    set_flat(0, 0);
    for (int i = 0; i < N; i++) img_mag[i] = (i * 37) % 200;
    send_frame(7);
    repeat (5) @(posedge clk);
    #1;
    cap.delete(); send_frame(N); check_frame("restart");

    // Three kept centers at 10/50/150 for threshold classing
    set_flat(0, 0);
    set_px(1, 1, 10, 0); set_px(2, 2, 50, 0); set_px(3, 3, 150, 0);
    cap.delete(); send_frame(N); check_frame("classes");
    chk("class_hi", (cap.size() > 18) ? int'(cap[18][9:2]) : -1, classify(150));

    // Reset mid-frame, then a clean frame
    send_frame(8);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_m_valid", int'(m_valid), 0);
    chk("midrst_s_ready", int'(s_ready), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      img_mag[i] = $urandom_range(0, 4095); img_dir[i] = $urandom_range(0, 7);
    end
    cap.delete(); send_frame(N); check_frame("after_rst");

    // Random frames with random ready and input gaps
    ready_mode = 2; gaps = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) begin
        img_mag[i] = $urandom_range(0, 6) * 60; img_dir[i] = $urandom_range(0, 7);
      end
      cap.delete(); send_frame(N); check_frame($sformatf("rand%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nms_stream.md
NMS_STREAM -- requirements
Module: nms_stream

Interface
REQ-001 SHALL have parameter MAG_WIDTH, default 12, meaning gradient magnitude width.
REQ-002 SHALL have parameter IMG_W, default 640, meaning pixels per line (>=3).
REQ-003 SHALL have parameter IMG_H, default 480, meaning lines per frame (>=3).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have ports s_valid input 1, s_ready output 1; input pixel handshake.
REQ-007 SHALL have ports s_mag input MAG_WIDTH and s_dir input 3; raster-order magnitude and direction code.
REQ-008 SHALL have port s_sof  input  1  marks first pixel of a frame.
REQ-009 SHALL have ports m_valid output 1, m_ready input 1; output handshake.
REQ-010 SHALL have ports m_data output 8, m_sof output 1, m_eol output 1; thinned pixel, frame start, line end.
REQ-011 SHALL have ports thr_lo and thr_hi, input MAG_WIDTH each; hysteresis thresholds (used only with NMS_HYST_EN).

Function
REQ-012 SHALL buffer two lines of {mag,dir} in internal line buffers (depth IMG_W) and form a 3x3 magnitude window plus center direction.
REQ-013 SHALL select neighbours by center dir: 0,7 W/E; 1 NE/SW; 2,4 N/S; 3,5,6 NW/SE.
REQ-014 SHALL keep center iff center>=n1 and center>=n2, else 0; kept value saturates to 255 when >255.
REQ-015 SHALL output 0 for every border pixel (x=0, x=IMG_W-1, y=0, y=IMG_H-1).
REQ-016 SHALL emit exactly IMG_W*IMG_H output pixels per frame in raster order; m_sof on (0,0), m_eol on x=IMG_W-1.
REQ-017 SHALL use FSM IDLE->FILL on s_valid&&s_sof accepted; FILL->RUN after IMG_W+1 pixels accepted; RUN->FLUSH after IMG_W*IMG_H pixels accepted; FLUSH->IDLE after last output handshake.
REQ-018 SHALL in IDLE drop pixels with s_sof=0 while holding s_ready=1.
REQ-019 SHALL in FLUSH hold s_ready=0 and internally inject IMG_W+1 zero pixels to drain the window.
REQ-020 SHALL produce output for center (x,y) registered one cycle after input (x+1,y+1) (or its flush equivalent) is accepted.
REQ-021 SHALL stall whole pipeline when m_valid=1 and m_ready=0; m_data/m_sof/m_eol stable while stalled.
REQ-022 SHALL drive s_ready=1 in FILL/RUN only when (!m_valid || m_ready).
REQ-023 SHALL treat s_sof accepted in FILL/RUN as frame restart: counters cleared, state FILL, no output for abandoned frame's pending pixels.
REQ-024 SHALL compare magnitudes unsigned at full MAG_WIDTH; ties keep center.

Reset
REQ-025 SHALL on rst_n=0 at clk edge set state IDLE, counters 0, m_valid=0, m_data=0, m_sof=0, m_eol=0, s_ready=0 during reset.
REQ-026 SHALL on reset mid-frame discard all buffered data; line buffer contents need not be cleared.

Configuration
REQ-027 SHALL with NMS_HYST_EN defined classify kept center c: c>=thr_hi -> 255, thr_lo<=c<thr_hi -> 128, else 0; suppressed -> 0.
REQ-028 SHALL without NMS_HYST_EN ignore thr_lo/thr_hi and output saturated magnitude per REQ-014.

Structure
REQ-029 SHALL place direction code constants (DIR_EW, DIR_NESW, DIR_NS, DIR_NWSE) and FSM state typedef in shared package nms_pkg.
REQ-030 SHALL instantiate sub-module nms_line_buf (single-port-per-cycle FIFO-style line delay, depth IMG_W, width MAG_WIDTH+3) twice.

Verification
REQ-031 SHALL test IMG_W=IMG_H=5, all mag=10, dir=0 -> 25 outputs, border 0, interior 9 pixels =10.
REQ-032 SHALL test 5x5, center (2,2) mag=300 dir=2, N=200, S=310 -> out(2,2)=0; with S=299 -> 255.
REQ-033 SHALL test dir=6 at (2,2) mag=50, NW=50, SE=49 -> out=50 (tie kept).
REQ-034 SHALL test m_ready toggled 1/0 every cycle over 5x5 frame -> 25 outputs, no loss or duplicate, m_eol on every 5th.
REQ-035 SHALL test s_sof reasserted after 7 pixels, then full frame -> exactly 25 outputs, m_sof once.
REQ-036 SHALL test NMS_HYST_EN, thr_lo=20, thr_hi=100, kept centers 10/50/150 -> 0/128/255.
